// File: rtl/sram_bus_arbiter_if.sv
// Bus bundle for the SRAM bus arbiter.
// The arbiter side uses the master modport because it masters the shared memory bus.
// The slave modport is the environment's view, covering the fetch/data requesters and the memory.
interface sram_bus_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          inst_req;
    logic [AW-1:0] inst_addr;
    logic [DW-1:0] inst_rdata;
    logic          inst_data_ok;

    logic          data_req;
    logic          data_wr;
    logic [1:0]    data_size;
    logic [3:0]    data_wstrb;
    logic [AW-1:0] data_addr;
    logic [DW-1:0] data_wdata;
    logic [DW-1:0] data_rdata;
    logic          data_data_ok;

    logic          flush;

    logic          bus_req;
    logic          bus_wr;
    logic [1:0]    bus_size;
    logic [3:0]    bus_wstrb;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic          bus_addr_ok;
    logic          bus_data_ok;
    logic [DW-1:0] bus_rdata;

    logic          inst_stall;
    logic          data_stall;

    modport master (
        input  inst_req, inst_addr,
        output inst_rdata, inst_data_ok,
        input  data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
        output data_rdata, data_data_ok,
        input  flush,
        output bus_req, bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata,
        input  bus_addr_ok, bus_data_ok, bus_rdata,
        output inst_stall, data_stall
    );

    modport slave (
        output inst_req, inst_addr,
        input  inst_rdata, inst_data_ok,
        output data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
        input  data_rdata, data_data_ok,
        output flush,
        input  bus_req, bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata,
        output bus_addr_ok, bus_data_ok, bus_rdata,
        input  inst_stall, data_stall
    );
endinterface

// File: rtl/sram_bus_arbiter.sv
// Round-robin arbiter sharing one SRAM-like bus between instruction fetch and data access.
// Only one transaction is outstanding at a time, and all bus outputs come from registers.
// An exception flush makes the in-flight fetch finish silently so its data never reaches the pipeline.
module sram_bus_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input logic                 clk,
    input logic                 rst,
    sram_bus_arbiter_if.master  busIf
);
    typedef enum logic [2:0] {IDLE, I_ADDR, I_WAIT, D_ADDR, D_WAIT} StateType;
    typedef enum logic {GRANT_INST, GRANT_DATA} GrantType;

    StateType      state, stateNext;
    GrantType      lastGrant;
    logic          discard;

    logic          grantInst, grantData;
    logic          instDone, dataDone;
    logic          instEligible, dataEligible;
    logic          instDeliver;

    logic          busReq, busWr;
    logic [1:0]    busSize;
    logic [3:0]    busWstrb;
    logic [AW-1:0] busAddr;
    logic [DW-1:0] busWdata;
    logic [DW-1:0] instRdata, dataRdata;
    logic          instDataOk, dataDataOk;

    // A requester that is being acknowledged this cycle is still showing its old request, so it sits out.
    assign instEligible = busIf.inst_req & ~instDataOk;
    assign dataEligible = busIf.data_req & ~dataDataOk;

    // A flushed fetch still completes on the bus, but its result is dropped.
    assign instDeliver  = instDone & ~discard & ~busIf.flush;

    // State register for the transaction sequencer.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= stateNext;
    end

    // Next state, grant decision and completion detection.
    always_comb begin
        stateNext = state;
        grantInst = 1'b0;
        grantData = 1'b0;
        instDone  = 1'b0;
        dataDone  = 1'b0;
        case (state)
            IDLE: begin
                if (instEligible && dataEligible) begin
                    if (lastGrant == GRANT_INST) grantData = 1'b1;
                    else                         grantInst = 1'b1;
                end else if (instEligible) begin
                    grantInst = 1'b1;
                end else if (dataEligible) begin
                    grantData = 1'b1;
                end
                if (grantInst) stateNext = I_ADDR;
                if (grantData) stateNext = D_ADDR;
            end
            I_ADDR: begin
                if (busIf.bus_addr_ok) begin
                    if (busIf.bus_data_ok) begin
                        instDone  = 1'b1;
                        stateNext = IDLE;
                    end else begin
                        stateNext = I_WAIT;
                    end
                end
            end
            I_WAIT: begin
                if (busIf.bus_data_ok) begin
                    instDone  = 1'b1;
                    stateNext = IDLE;
                end
            end
            D_ADDR: begin
                if (busIf.bus_addr_ok) begin
                    if (busIf.bus_data_ok) begin
                        dataDone  = 1'b1;
                        stateNext = IDLE;
                    end else begin
                        stateNext = D_WAIT;
                    end
                end
            end
            D_WAIT: begin
                if (busIf.bus_data_ok) begin
                    dataDone  = 1'b1;
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Bus request registers: fields are captured on the grant edge and held until the next grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            busReq    <= 1'b0;
            busWr     <= 1'b0;
            busSize   <= 2'd0;
            busWstrb  <= 4'd0;
            busAddr   <= '0;
            busWdata  <= '0;
            lastGrant <= GRANT_INST;
        end else begin
            busReq <= (stateNext == I_ADDR) || (stateNext == D_ADDR);
            if (grantInst) begin
                busWr     <= 1'b0;
                busSize   <= 2'd2;
                busWstrb  <= 4'd0;
                busAddr   <= busIf.inst_addr;
                busWdata  <= '0;
                lastGrant <= GRANT_INST;
            end else if (grantData) begin
                busWr     <= busIf.data_wr;
                busSize   <= busIf.data_size;
                busWstrb  <= busIf.data_wstrb;
                busAddr   <= busIf.data_addr;
                busWdata  <= busIf.data_wdata;
                lastGrant <= GRANT_DATA;
            end
        end
    end

    // Completion pulses and read-data capture for both requesters.
    always_ff @(posedge clk) begin
        if (rst) begin
            instDataOk <= 1'b0;
            dataDataOk <= 1'b0;
            instRdata  <= '0;
            dataRdata  <= '0;
        end else begin
            instDataOk <= instDeliver;
            dataDataOk <= dataDone;
            if (instDeliver)
                instRdata <= busIf.bus_rdata;
            if (dataDone && !busWr)
                dataRdata <= busIf.bus_rdata;
        end
    end

    // Remember a flush seen during a fetch, so its eventual data is dropped.
    // The flag is cleared when the sequencer goes back to idle.
    always_ff @(posedge clk) begin
        if (rst)
            discard <= 1'b0;
        else if (stateNext == IDLE)
            discard <= 1'b0;
        else if (busIf.flush && (state == I_ADDR || state == I_WAIT))
            discard <= 1'b1;
    end

    assign busIf.bus_req      = busReq;
    assign busIf.bus_wr       = busWr;
    assign busIf.bus_size     = busSize;
    assign busIf.bus_wstrb    = busWstrb;
    assign busIf.bus_addr     = busAddr;
    assign busIf.bus_wdata    = busWdata;
    assign busIf.inst_rdata   = instRdata;
    assign busIf.data_rdata   = dataRdata;
    assign busIf.inst_data_ok = instDataOk;
    assign busIf.data_data_ok = dataDataOk;
    assign busIf.inst_stall   = busIf.inst_req & ~instDataOk;
    assign busIf.data_stall   = busIf.data_req & ~dataDataOk;
endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed testbench for sram_bus_arbiter.
// Inputs change 1 ns after each rising edge, and outputs are checked at that same point.
module tb_sram_bus_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    sram_bus_arbiter_if #(.AW(32), .DW(32)) busIf ();

    sram_bus_arbiter #(.AW(32), .DW(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .busIf (busIf)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Advance one clock and settle just after the rising edge
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    // Compare one observed value against its hand-computed expectation
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drive every environment-side input to idle
    task automatic clearInputs();
        busIf.inst_req    = 1'b0;
        busIf.inst_addr   = '0;
        busIf.data_req    = 1'b0;
        busIf.data_wr     = 1'b0;
        busIf.data_size   = 2'd0;
        busIf.data_wstrb  = 4'd0;
        busIf.data_addr   = '0;
        busIf.data_wdata  = '0;
        busIf.flush       = 1'b0;
        busIf.bus_addr_ok = 1'b0;
        busIf.bus_data_ok = 1'b0;
        busIf.bus_rdata   = '0;
    endtask

    // Set the slave handshake inputs for the next edge
    task automatic slave(input logic addrOk, input logic dataOk, input logic [31:0] rdata);
        busIf.bus_addr_ok = addrOk;
        busIf.bus_data_ok = dataOk;
        busIf.bus_rdata   = rdata;
    endtask

    initial begin
        clearInputs();
        #1;

        // Reset state
        rst = 1'b1;
        applyStimulus();
        applyStimulus();
        rst = 1'b0;
        checkOutput("rst_bus_req", {31'd0, busIf.bus_req}, 32'd0);
        checkOutput("rst_inst_ok", {31'd0, busIf.inst_data_ok}, 32'd0);
        checkOutput("rst_data_ok", {31'd0, busIf.data_data_ok}, 32'd0);
        checkOutput("rst_bus_addr", busIf.bus_addr, 32'd0);

        // Lone fetch, zero-wait slave
        busIf.inst_req  = 1'b1;
        busIf.inst_addr = 32'hBFC00000;
        #1;
        checkOutput("f1_stall_pre", {31'd0, busIf.inst_stall}, 32'd1);
        applyStimulus();
        checkOutput("f1_bus_req", {31'd0, busIf.bus_req}, 32'd1);
        checkOutput("f1_bus_addr", busIf.bus_addr, 32'hBFC00000);
        checkOutput("f1_bus_wr", {31'd0, busIf.bus_wr}, 32'd0);
        checkOutput("f1_bus_size", {30'd0, busIf.bus_size}, 32'd2);
        checkOutput("f1_bus_wstrb", {28'd0, busIf.bus_wstrb}, 32'd0);
        checkOutput("f1_inst_ok_early", {31'd0, busIf.inst_data_ok}, 32'd0);
        slave(1'b1, 1'b1, 32'h24080001);
        applyStimulus();
        checkOutput("f1_inst_ok", {31'd0, busIf.inst_data_ok}, 32'd1);
        checkOutput("f1_inst_rdata", busIf.inst_rdata, 32'h24080001);
        checkOutput("f1_inst_stall", {31'd0, busIf.inst_stall}, 32'd0);
        checkOutput("f1_bus_req_done", {31'd0, busIf.bus_req}, 32'd0);
        busIf.inst_req = 1'b0;
        slave(1'b0, 1'b0, 32'h0);
        applyStimulus();
        checkOutput("f1_inst_ok_pulse", {31'd0, busIf.inst_data_ok}, 32'd0);

        // Tie after reset: data first, then fetch, then data again on the next tie
        rst = 1'b1;
        applyStimulus();
        rst = 1'b0;
        busIf.inst_req  = 1'b1;
        busIf.inst_addr = 32'hBFC00004;
        busIf.data_req  = 1'b1;
        busIf.data_wr   = 1'b0;
        busIf.data_size = 2'd2;
        busIf.data_addr = 32'h80000010;
        applyStimulus();
        checkOutput("tie1_bus_addr", busIf.bus_addr, 32'h80000010);
        checkOutput("tie1_inst_stall", {31'd0, busIf.inst_stall}, 32'd1);
        checkOutput("tie1_data_stall", {31'd0, busIf.data_stall}, 32'd1);
        slave(1'b1, 1'b1, 32'h11112222);
        applyStimulus();
        checkOutput("tie1_data_ok", {31'd0, busIf.data_data_ok}, 32'd1);
        checkOutput("tie1_data_rdata", busIf.data_rdata, 32'h11112222);
        checkOutput("tie1_data_stall_done", {31'd0, busIf.data_stall}, 32'd0);
        busIf.data_req = 1'b0;
        slave(1'b0, 1'b0, 32'h0);
        applyStimulus();
        checkOutput("tie1_fetch_req", {31'd0, busIf.bus_req}, 32'd1);
        checkOutput("tie1_fetch_addr", busIf.bus_addr, 32'hBFC00004);
        slave(1'b1, 1'b1, 32'h33334444);
        applyStimulus();
        checkOutput("tie1_inst_ok", {31'd0, busIf.inst_data_ok}, 32'd1);
        checkOutput("tie1_inst_rdata", busIf.inst_rdata, 32'h33334444);
        busIf.inst_req = 1'b0;
        slave(1'b0, 1'b0, 32'h0);
        applyStimulus();
        busIf.inst_req  = 1'b1;
        busIf.inst_addr = 32'hBFC00008;
        busIf.data_req  = 1'b1;
        busIf.data_addr = 32'h80000014;
        applyStimulus();
        checkOutput("tie2_bus_addr", busIf.bus_addr, 32'h80000014);
        slave(1'b1, 1'b1, 32'h55556666);
        applyStimulus();
        checkOutput("tie2_data_ok", {31'd0, busIf.data_data_ok}, 32'd1);
        checkOutput("tie2_data_rdata", busIf.data_rdata, 32'h55556666);
        busIf.data_req = 1'b0;
        slave(1'b0, 1'b0, 32'h0);
        applyStimulus();
        checkOutput("tie2_fetch_addr", busIf.bus_addr, 32'hBFC00008);
        slave(1'b1, 1'b1, 32'h77778888);
        applyStimulus();
        checkOutput("tie2_inst_rdata", busIf.inst_rdata, 32'h77778888);
        busIf.inst_req = 1'b0;
        slave(1'b0, 1'b0, 32'h0);
        applyStimulus();

        // Store with a slow slave: fields held in D_ADDR, single completion pulse
        busIf.data_req   = 1'b1;
        busIf.data_wr    = 1'b1;
        busIf.data_size  = 2'd2;
        busIf.data_wstrb = 4'hF;
        busIf.data_addr  = 32'h80000020;
        busIf.data_wdata = 32'hDEADBEEF;
        applyStimulus();
        checkOutput("st_bus_wr", {31'd0, busIf.bus_wr}, 32'd1);
        checkOutput("st_bus_wstrb", {28'd0, busIf.bus_wstrb}, 32'hF);
        checkOutput("st_bus_size", {30'd0, busIf.bus_size}, 32'd2);
        checkOutput("st_bus_wdata", busIf.bus_wdata, 32'hDEADBEEF);
        for (int i = 0; i < 2; i++) begin
            applyStimulus();
            checkOutput("st_hold_req", {31'd0, busIf.bus_req}, 32'd1);
            checkOutput("st_hold_addr", busIf.bus_addr, 32'h80000020);
            checkOutput("st_hold_stall", {31'd0, busIf.data_stall}, 32'd1);
        end
        slave(1'b1, 1'b0, 32'hFFFFFFFF);
        applyStimulus();
        checkOutput("st_wait_req", {31'd0, busIf.bus_req}, 32'd0);
        checkOutput("st_wait_stall", {31'd0, busIf.data_stall}, 32'd1);
        slave(1'b0, 1'b0, 32'hFFFFFFFF);
        applyStimulus();
        checkOutput("st_wait_ok", {31'd0, busIf.data_data_ok}, 32'd0);
        slave(1'b0, 1'b1, 32'hFFFFFFFF);
        applyStimulus();
        checkOutput("st_data_ok", {31'd0, busIf.data_data_ok}, 32'd1);
        checkOutput("st_rdata_kept", busIf.data_rdata, 32'h55556666);
        busIf.data_req = 1'b0;
        busIf.data_wr  = 1'b0;
        slave(1'b0, 1'b0, 32'h0);
        applyStimulus();
        checkOutput("st_single_pulse", {31'd0, busIf.data_data_ok}, 32'd0);

        // Flush during I_WAIT drops the fetch result; the held fetch is then re-granted
        busIf.inst_req  = 1'b1;
        busIf.inst_addr = 32'hBFC00010;
        applyStimulus();
        slave(1'b1, 1'b0, 32'h0);
        applyStimulus();
        slave(1'b0, 1'b0, 32'h0);
        busIf.flush = 1'b1;
        applyStimulus();
        busIf.flush = 1'b0;
        applyStimulus();
        slave(1'b0, 1'b1, 32'hAAAAAAAA);
        applyStimulus();
        checkOutput("fl_no_inst_ok", {31'd0, busIf.inst_data_ok}, 32'd0);
        checkOutput("fl_rdata_kept", busIf.inst_rdata, 32'h77778888);
        checkOutput("fl_stall", {31'd0, busIf.inst_stall}, 32'd1);
        slave(1'b0, 1'b0, 32'h0);
        applyStimulus();
        checkOutput("fl_regrant_req", {31'd0, busIf.bus_req}, 32'd1);
        checkOutput("fl_regrant_addr", busIf.bus_addr, 32'hBFC00010);
        slave(1'b1, 1'b1, 32'hBBBBBBBB);
        applyStimulus();
        checkOutput("fl_next_ok", {31'd0, busIf.inst_data_ok}, 32'd1);
        checkOutput("fl_next_rdata", busIf.inst_rdata, 32'hBBBBBBBB);
        busIf.inst_req = 1'b0;
        slave(1'b0, 1'b0, 32'h0);
        applyStimulus();

        // Reset during D_WAIT abandons the load; a late data_ok is ignored
        busIf.data_req  = 1'b1;
        busIf.data_wr   = 1'b0;
        busIf.data_addr = 32'h80000030;
        applyStimulus();
        slave(1'b1, 1'b0, 32'h0);
        applyStimulus();
        slave(1'b0, 1'b0, 32'h0);
        rst = 1'b1;
        applyStimulus();
        checkOutput("rw_bus_req", {31'd0, busIf.bus_req}, 32'd0);
        checkOutput("rw_data_ok", {31'd0, busIf.data_data_ok}, 32'd0);
        checkOutput("rw_inst_ok", {31'd0, busIf.inst_data_ok}, 32'd0);
        rst = 1'b0;
        busIf.data_req = 1'b0;
        slave(1'b0, 1'b1, 32'hCCCCCCCC);
        applyStimulus();
        checkOutput("rw_late_ok", {31'd0, busIf.data_data_ok}, 32'd0);
        checkOutput("rw_late_rdata", busIf.data_rdata, 32'd0);
        checkOutput("rw_late_req", {31'd0, busIf.bus_req}, 32'd0);
        slave(1'b0, 1'b0, 32'h0);
        applyStimulus();

        // addr_ok and data_ok together in I_ADDR skip I_WAIT
        busIf.inst_req  = 1'b1;
        busIf.inst_addr = 32'hBFC00020;
        applyStimulus();
        applyStimulus();
        checkOutput("zw_hold_req", {31'd0, busIf.bus_req}, 32'd1);
        checkOutput("zw_hold_addr", busIf.bus_addr, 32'hBFC00020);
        slave(1'b1, 1'b1, 32'h12345678);
        applyStimulus();
        checkOutput("zw_inst_ok", {31'd0, busIf.inst_data_ok}, 32'd1);
        checkOutput("zw_inst_rdata", busIf.inst_rdata, 32'h12345678);
        busIf.inst_req = 1'b0;
        slave(1'b0, 1'b0, 32'h0);
        applyStimulus();
        checkOutput("zw_pulse_end", {31'd0, busIf.inst_data_ok}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
